// File: rtl/sound_pkg.sv
// -----------------------------------------------------------------------------
// sound_pkg
// Shared types and constants for the sound sequencer:
//   MODE_TYPES  - audible-state indication driven to the 'state' port
//   fsm_state_t - sequencer FSM states
//   melody_t    - jingle selector
//   note frequency (Hz) and duration (units) constants for both jingles
// -----------------------------------------------------------------------------
package sound_pkg;

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } MODE_TYPES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } fsm_state_t;

    typedef enum logic {
        EAT   = 1'b0,
        CRASH = 1'b1
    } melody_t;

    // Note frequencies in Hz
    localparam logic [8:0] FREQ_C3 = 9'd131;
    localparam logic [8:0] FREQ_C4 = 9'd262;
    localparam logic [8:0] FREQ_E4 = 9'd330;
    localparam logic [8:0] FREQ_G4 = 9'd392;

    // Note durations in units
    localparam logic [3:0] DUR_EAT_0   = 4'd2;
    localparam logic [3:0] DUR_EAT_1   = 4'd3;
    localparam logic [3:0] DUR_CRASH   = 4'd4;
    localparam logic [3:0] DUR_CRASH_3 = 4'd8;

endpackage

// File: rtl/sound_rom.sv
// -----------------------------------------------------------------------------
// sound_rom
// Combinational melody table.
//   melody : jingle selector (EAT / CRASH)
//   idx    : note index within the jingle
//   freq   : note frequency in Hz
//   dur    : note duration in units
//   last   : high when idx is the final note of the jingle
// -----------------------------------------------------------------------------
module sound_rom
    import sound_pkg::*;
(
    input  melody_t    melody,
    input  logic [1:0] idx,
    output logic [8:0] freq,
    output logic [3:0] dur,
    output logic       last
);

    // NOTE: every output gets a default before the case so that no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        freq = 9'd0;
        dur  = 4'd1;
        last = 1'b1;
        unique case ({melody, idx})
            {EAT,   2'd0}: begin freq = FREQ_C4; dur = DUR_EAT_0;   last = 1'b0; end
            {EAT,   2'd1}: begin freq = FREQ_G4; dur = DUR_EAT_1;   last = 1'b1; end
            {CRASH, 2'd0}: begin freq = FREQ_G4; dur = DUR_CRASH;   last = 1'b0; end
            {CRASH, 2'd1}: begin freq = FREQ_E4; dur = DUR_CRASH;   last = 1'b0; end
            {CRASH, 2'd2}: begin freq = FREQ_C4; dur = DUR_CRASH;   last = 1'b0; end
            {CRASH, 2'd3}: begin freq = FREQ_C3; dur = DUR_CRASH_3; last = 1'b1; end
            default:       begin freq = 9'd0;    dur = 4'd1;        last = 1'b1; end
        endcase
    end

endmodule

// File: rtl/sound_sequencer.sv
// -----------------------------------------------------------------------------
// sound_sequencer
// Plays the EAT or CRASH jingle as a sequence of notes separated by one-unit
// gaps, driving a frequency word to the oscillator stage.
//   clk, rst           : clock, asynchronous active-high reset
//   eat_evt, crash_evt : one-cycle jingle requests (CRASH has priority)
//   mute               : suppresses playSound only; sequencing is unaffected
//   freq               : current note frequency in Hz (held through gaps)
//   playSound          : note sounding and not muted
//   state              : ON while a note is sounding, OFF otherwise
//   busy               : jingle in progress
//   done               : one-cycle pulse on normal jingle completion
// -----------------------------------------------------------------------------
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int unsigned TICKS_PER_UNIT = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       eat_evt,
    input  logic       crash_evt,
    input  logic       mute,
    output logic [8:0] freq,
    output logic       playSound,
    output MODE_TYPES  state,
    output logic       busy,
    output logic       done
);

    localparam logic [23:0] GAP_LAST  = 24'(TICKS_PER_UNIT - 1);
    localparam logic [23:0] TICKS_24  = 24'(TICKS_PER_UNIT);

    fsm_state_t  fsm_q,    fsm_d;
    melody_t     melody_q, melody_d;
    logic [1:0]  idx_q,    idx_d;
    logic [23:0] cnt_q,    cnt_d;
    logic [8:0]  freq_q,   freq_d;
    logic        done_q,   done_d;

    melody_t     rom_melody;
    logic [1:0]  rom_idx;
    logic [8:0]  rom_freq;
    logic [3:0]  rom_dur;
    logic        rom_last;
    logic [23:0] note_last;
    logic        start_crash;
    logic        start_eat;

    sound_rom u_rom (
        .melody (rom_melody),
        .idx    (rom_idx),
        .freq   (rom_freq),
        .dur    (rom_dur),
        .last   (rom_last)
    );

    always_comb begin
        // CRASH pre-empts anything except itself; EAT only starts from idle
        // or restarts itself.
        start_crash = crash_evt && !((fsm_q != IDLE) && (melody_q == CRASH));
        start_eat   = !start_crash && eat_evt &&
                      ((fsm_q == IDLE) || (melody_q == EAT));

        // One ROM port: the starting note, the upcoming note while in a gap,
        // or the current note otherwise (to read its 'last' flag).
        if (start_crash) begin
            rom_melody = CRASH;
            rom_idx    = 2'd0;
        end else if (start_eat) begin
            rom_melody = EAT;
            rom_idx    = 2'd0;
        end else if (fsm_q == GAP) begin
            rom_melody = melody_q;
            rom_idx    = idx_q + 2'd1;
        end else begin
            rom_melody = melody_q;
            rom_idx    = idx_q;
        end

        note_last = 24'(rom_dur) * TICKS_24 - 24'd1;

        fsm_d    = fsm_q;
        melody_d = melody_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        freq_d   = freq_q;
        done_d   = 1'b0;

        if (start_crash || start_eat) begin
            fsm_d    = NOTE;
            melody_d = rom_melody;
            idx_d    = 2'd0;
            cnt_d    = note_last;
            freq_d   = rom_freq;
        end else begin
            unique case (fsm_q)
                IDLE: ;
                NOTE: begin
                    if (cnt_q != 24'd0) begin
                        cnt_d = cnt_q - 24'd1;
                    end else if (rom_last) begin
                        fsm_d  = IDLE;
                        idx_d  = 2'd0;
                        done_d = 1'b1;
                    end else begin
                        fsm_d = GAP;
                        cnt_d = GAP_LAST;
                    end
                end
                GAP: begin
                    if (cnt_q != 24'd0) begin
                        cnt_d = cnt_q - 24'd1;
                    end else begin
                        fsm_d  = NOTE;
                        idx_d  = rom_idx;
                        cnt_d  = note_last;
                        freq_d = rom_freq;
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q    <= IDLE;
            melody_q <= EAT;
            idx_q    <= 2'd0;
            cnt_q    <= 24'd0;
            freq_q   <= 9'd0;
            done_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            melody_q <= melody_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            freq_q   <= freq_d;
            done_q   <= done_d;
        end
    end

    assign freq      = freq_q;
    assign done      = done_q;
    assign busy      = (fsm_q != IDLE);
    assign state     = (fsm_q == NOTE) ? ON : OFF;
    assign playSound = (fsm_q == NOTE) && !mute;

endmodule

// File: tb/tb_sound_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sound_sequencer
// Self-checking bench for sound_sequencer with TICKS_PER_UNIT = 4. A timeline
// reference model (jingle position in cycles since start) predicts every
// output on every cycle; directed tables and sequences pin the key timings.
// -----------------------------------------------------------------------------
module tb_sound_sequencer;
    import sound_pkg::*;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       eat_evt = 1'b0;
    logic       crash_evt = 1'b0;
    logic       mute = 1'b0;
    logic [8:0] freq;
    logic       playSound;
    MODE_TYPES  state_o;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    sound_sequencer #(.TICKS_PER_UNIT(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .eat_evt   (eat_evt),
        .crash_evt (crash_evt),
        .mute      (mute),
        .freq      (freq),
        .playSound (playSound),
        .state     (state_o),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int mel_f [2][4] = '{'{262, 392, 0, 0}, '{392, 330, 262, 131}};
    int mel_d [2][4] = '{'{2, 3, 0, 0},     '{4, 4, 4, 8}};
    int mel_n [2]    = '{2, 4};

    bit m_active = 0;
    int m_mel    = 0;
    int m_t      = 0;
    int m_last_f = 0;
    bit m_done   = 0;
    bit m_note   = 0;
    int m_f      = 0;

    function automatic int total_len(int m);
        int s = 0;
        for (int i = 0; i < mel_n[m]; i++) s += mel_d[m][i] * T;
        return s + (mel_n[m] - 1) * T;
    endfunction

    task automatic model_update(input bit e, input bit c, input bit r);
        bit acc_c, acc_e;
        int pos, span;
        m_done = 0;
        if (r) begin
            m_active = 0; m_t = 0; m_last_f = 0;
        end else begin
            acc_c = c && !(m_active && m_mel == 1);
            acc_e = !acc_c && e && (!m_active || m_mel == 0);
            if (acc_c || acc_e) begin
                m_active = 1; m_mel = acc_c ? 1 : 0; m_t = 0;
            end else if (m_active) begin
                m_t++;
                if (m_t == total_len(m_mel)) begin
                    m_active = 0; m_done = 1;
                end
            end
        end
        m_note = 0;
        m_f    = m_last_f;
        if (m_active) begin
            pos = m_t;
            for (int i = 0; i < mel_n[m_mel]; i++) begin
                span = mel_d[m_mel][i] * T;
                if (pos < span) begin m_note = 1; m_f = mel_f[m_mel][i]; break; end
                pos -= span;
                if (pos < T) begin m_f = mel_f[m_mel][i]; break; end
                pos -= T;
            end
            m_last_f = m_f;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        check("model_freq",  32'(freq), 32'(m_f));
        check("model_state", 32'(state_o == ON), 32'(m_note));
        check("model_play",  32'(playSound), 32'(m_note && !mute));
        check("model_busy",  32'(busy), 32'(m_active));
        check("model_done",  32'(done), 32'(m_done));
    endtask

    task automatic step(input bit e, input bit c, input bit m, input bit r);
        eat_evt = e; crash_evt = c; mute = m; rst = r;
        @(posedge clk);
        model_update(e, c, r);
        #1;
        compare_all();
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && m_active; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    typedef struct {
        int         cyc;
        logic [8:0] f;
        logic       ps;
        logic       st;
        logic       bz;
        logic       dn;
    } chk_t;

    chk_t eat_tbl [8];

    task automatic run_eat_table(input bit m, input string tag);
        step(1, 0, m, 0);
        for (int k = 1; k <= 26; k++) begin
            for (int j = 0; j < 8; j++) begin
                if (eat_tbl[j].cyc == k) begin
                    check({tag, "_freq"},  32'(freq), 32'(eat_tbl[j].f));
                    check({tag, "_play"},  32'(playSound), 32'(eat_tbl[j].ps && !m));
                    check({tag, "_state"}, 32'(state_o == ON), 32'(eat_tbl[j].st));
                    check({tag, "_busy"},  32'(busy), 32'(eat_tbl[j].bz));
                    check({tag, "_done"},  32'(done), 32'(eat_tbl[j].dn));
                end
            end
            step(0, 0, m, 0);
        end
    endtask

    initial begin
        int done_cyc;
        eat_tbl[0] = '{1,  9'd262, 1'b1, 1'b1, 1'b1, 1'b0};
        eat_tbl[1] = '{8,  9'd262, 1'b1, 1'b1, 1'b1, 1'b0};
        eat_tbl[2] = '{9,  9'd262, 1'b0, 1'b0, 1'b1, 1'b0};
        eat_tbl[3] = '{12, 9'd262, 1'b0, 1'b0, 1'b1, 1'b0};
        eat_tbl[4] = '{13, 9'd392, 1'b1, 1'b1, 1'b1, 1'b0};
        eat_tbl[5] = '{24, 9'd392, 1'b1, 1'b1, 1'b1, 1'b0};
        eat_tbl[6] = '{25, 9'd392, 1'b0, 1'b0, 1'b0, 1'b1};
        eat_tbl[7] = '{26, 9'd392, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("rst_freq",  32'(freq), 32'd0);
        check("rst_state", 32'(state_o == ON), 32'd0);
        check("rst_play",  32'(playSound), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

        // EAT timing, unmuted then muted
        run_eat_table(1'b0, "eat");
        run_eat_table(1'b1, "eat_mute");
        drain();

        // CRASH: note starts and done at cycle 93
        step(0, 1, 0, 0);
        done_cyc = -1;
        for (int k = 1; k <= 100; k++) begin
            if (k == 1)  check("crash_n0", 32'(freq), 32'd392);
            if (k == 21) check("crash_n1", 32'(freq), 32'd330);
            if (k == 41) check("crash_n2", 32'(freq), 32'd262);
            if (k == 61) check("crash_n3", 32'(freq), 32'd131);
            if (done === 1'b1 && done_cyc < 0) done_cyc = k;
            step(0, 0, 0, 0);
        end
        check("crash_done_cycle", 32'(done_cyc), 32'd93);
        drain();

        // EAT interrupted by CRASH at cycle 5
        step(1, 0, 0, 0);
        for (int k = 1; k <= 4; k++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        check("pre_freq",  32'(freq), 32'd392);
        check("pre_state", 32'(state_o == ON), 32'd1);
        for (int k = 7; k <= 22; k++) step(0, 0, 0, 0);
        check("pre_gap_state", 32'(state_o == ON), 32'd0);
        check("pre_gap_busy",  32'(busy), 32'd1);
        drain();

        // Simultaneous events, then EAT during CRASH
        step(1, 1, 0, 0);
        check("sim_freq", 32'(freq), 32'd392);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("ign_freq",  32'(freq), 32'd392);
        check("ign_state", 32'(state_o == ON), 32'd1);
        drain();

        // Reset mid-CRASH at cycle 10
        step(0, 1, 0, 0);
        for (int k = 1; k <= 9; k++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        check("abort_freq", 32'(freq), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_play", 32'(playSound), 32'd0);
        for (int k = 0; k < 100; k++) begin
            step(0, 0, 0, 0);
            check("abort_idle", 32'(busy | done | playSound), 32'd0);
        end

        // Randomized stimulus against the model
        for (int k = 0; k < 4000; k++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 499) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
